// File: rtl/cpu_step_ctrl_pkg.sv
// Shared definitions for the CPU run/step/breakpoint sequencer.
package cpu_step_ctrl_pkg;

   // Sequencer state; the encoding is visible on oState.
   typedef enum logic [1:0] {
      ST_HALT = 2'd0,
      ST_RUN  = 2'd1,
      ST_STEP = 2'd2,
      ST_BRK  = 2'd3
   } state_t;

   // Counter width able to hold 0..n-1, never narrower than one bit.
   function automatic int cntWidth(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // HALT and BRK both present a stopped core to the board.
   function automatic logic isHaltState(input state_t s);
      return (s == ST_HALT) || (s == ST_BRK);
   endfunction

endpackage

// File: rtl/cpu_step_ctrl_btn_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stability counter, and a
// registered one-cycle pulse on each debounced rising edge.
module btn_debounce
   import cpu_step_ctrl_pkg::*;
#(
   parameter int DEB = 1_000_000
) (
   input  logic iClk,
   input  logic iRst_n,
   input  logic iBtn,
   output logic oRise
);

   localparam int CW = cntWidth(DEB);

   logic          btnMeta_p0;
   logic          btnSync_p1;
   logic [CW-1:0] stableCnt;
   logic          level;
   logic          levelDly;

   // Bring the raw button into the iClk domain.
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         btnMeta_p0 <= 1'b0;
         btnSync_p1 <= 1'b0;
      end else begin
         btnMeta_p0 <= iBtn;
         btnSync_p1 <= btnMeta_p0;
      end
   end

   // Adopt the synchronized value only after DEB consecutive differing samples.
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         stableCnt <= '0;
         level     <= 1'b0;
      end else if (btnSync_p1 == level) begin
         stableCnt <= '0;
      end else if (stableCnt == CW'(DEB - 1)) begin
         stableCnt <= '0;
         level     <= btnSync_p1;
      end else begin
         stableCnt <= stableCnt + CW'(1);
      end
   end

   // One-cycle pulse when the debounced level goes high.
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         levelDly <= 1'b0;
         oRise    <= 1'b0;
      end else begin
         levelDly <= level;
         oRise    <= level & ~levelDly;
      end
   end

endmodule

// File: rtl/cpu_step_ctrl.sv
// Run/step/breakpoint sequencer producing a one-cycle clock enable per
// instruction for the single-cycle MIPS core.
module cpu_step_ctrl
   import cpu_step_ctrl_pkg::*;
#(
   parameter int DIV   = 20,
   parameter int DEB   = 1_000_000,
   parameter int CNT_W = 16
) (
   input  logic             iClk,
   input  logic             iRst_n,
   input  logic             iRun,
   input  logic             iStepBtn,
   input  logic             iBrkEn,
   input  logic [31:0]      iBrkAddr,
   input  logic [31:0]      iPC,
   output logic             oCpuEn,
   output logic [1:0]       oState,
   output logic             oHalted,
   output logic [CNT_W-1:0] oInstCnt
);

   localparam int DW = cntWidth(DIV);

   logic             runMeta_p0;
   logic             runSync_p1;
   logic             runDly_p2;
   logic             runRise;
   logic             stepReq;
   state_t           state;
   state_t           stateNxt;
   logic [DW-1:0]    divCnt;
   logic [DW-1:0]    divNxt;
   logic             enNxt;
   logic             cpuEn;
   logic             halted;
   logic [CNT_W-1:0] instCnt;
   logic             tick;
   logic             brkHit;

   btn_debounce #(.DEB(DEB)) uStepBtn (
      .iClk   (iClk),
      .iRst_n (iRst_n),
      .iBtn   (iStepBtn),
      .oRise  (stepReq)
   );

   // Synchronize the run switch and keep one delayed copy for edge detection.
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         runMeta_p0 <= 1'b0;
         runSync_p1 <= 1'b0;
         runDly_p2  <= 1'b0;
      end else begin
         runMeta_p0 <= iRun;
         runSync_p1 <= runMeta_p0;
         runDly_p2  <= runSync_p1;
      end
   end

   assign runRise = runSync_p1 & ~runDly_p2;
   assign tick    = (divCnt == DW'(DIV - 1));
   assign brkHit  = iBrkEn && (iPC == iBrkAddr);

   // Next state, divider and enable; the enable is registered so it lines up with the state.
   always_comb begin
      stateNxt = state;
      divNxt   = divCnt;
      enNxt    = 1'b0;
      case (state)
         ST_HALT: begin
            if (runRise) begin
               stateNxt = ST_RUN;
               divNxt   = '0;
            end else if (stepReq) begin
               stateNxt = ST_STEP;
               enNxt    = 1'b1;
            end
         end
         ST_RUN: begin
            if (!runSync_p1) begin
               stateNxt = ST_HALT;
               divNxt   = '0;
            end else if (tick) begin
               divNxt = '0;
               if (brkHit) stateNxt = ST_BRK;
               else        enNxt    = 1'b1;
            end else begin
               divNxt = divCnt + DW'(1);
            end
         end
         ST_BRK: begin
            if (!runSync_p1) begin
               stateNxt = ST_HALT;
            end else if (stepReq) begin
               stateNxt = ST_STEP;
               enNxt    = 1'b1;
            end
         end
         ST_STEP: stateNxt = ST_HALT;
         default: stateNxt = ST_HALT;
      endcase
   end

   // State, divider, registered outputs and the committed-instruction count.
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         state   <= ST_HALT;
         divCnt  <= '0;
         cpuEn   <= 1'b0;
         halted  <= 1'b1;
         instCnt <= '0;
      end else begin
         state   <= stateNxt;
         divCnt  <= divNxt;
         cpuEn   <= enNxt;
         halted  <= isHaltState(stateNxt);
         instCnt <= instCnt + CNT_W'(cpuEn);
      end
   end

   assign oCpuEn   = cpuEn;
   assign oState   = state;
   assign oHalted  = halted;
   assign oInstCnt = instCnt;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Self-checking bench for cpu_step_ctrl with a PC-advancing core model.
module tb_cpu_step_ctrl;

   localparam int DIV   = 4;
   localparam int DEB   = 8;
   localparam int CNT_W = 16;

   logic             iClk     = 1'b0;
   logic             iRst_n   = 1'b0;
   logic             iRun     = 1'b0;
   logic             iStepBtn = 1'b0;
   logic             iBrkEn   = 1'b0;
   logic [31:0]      iBrkAddr = 32'h0;
   logic [31:0]      iPC;
   logic             oCpuEn;
   logic [1:0]       oState;
   logic             oHalted;
   logic [CNT_W-1:0] oInstCnt;

   int nCmp = 0;
   int nBad = 0;

   cpu_step_ctrl #(.DIV(DIV), .DEB(DEB), .CNT_W(CNT_W)) dut (
      .iClk     (iClk),
      .iRst_n   (iRst_n),
      .iRun     (iRun),
      .iStepBtn (iStepBtn),
      .iBrkEn   (iBrkEn),
      .iBrkAddr (iBrkAddr),
      .iPC      (iPC),
      .oCpuEn   (oCpuEn),
      .oState   (oState),
      .oHalted  (oHalted),
      .oInstCnt (oInstCnt)
   );

   always #5 iClk = ~iClk;

   // Core model: each enabled cycle commits one instruction and PC moves on by 4.
   logic [31:0] pcModel;
   always @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n)     pcModel <= 32'h0;
      else if (oCpuEn) pcModel <= pcModel + 32'd4;
   end
   assign iPC = pcModel;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic cyc();
      @(negedge iClk);
   endtask

   task automatic applyReset();
      iRst_n = 1'b0; iRun = 1'b0; iStepBtn = 1'b0; iBrkEn = 1'b0; iBrkAddr = 32'h0;
      repeat (2) cyc();
      iRst_n = 1'b1;
      repeat (2) cyc();
   endtask

   task automatic test_reset();
      int pulses = 0;
      int notHalt = 0;
      cyc();
      iRst_n = 1'b0;
      #1;
      nCmp++; if (oState !== 2'd0)   begin nBad++; $display("FAIL reset_state: got %0d want 0", oState); end
      nCmp++; if (oHalted !== 1'b1)  begin nBad++; $display("FAIL reset_halted: got %b want 1", oHalted); end
      nCmp++; if (oCpuEn !== 1'b0)   begin nBad++; $display("FAIL reset_en: got %b want 0", oCpuEn); end
      nCmp++; if (oInstCnt !== '0)   begin nBad++; $display("FAIL reset_cnt: got %0h want 0", oInstCnt); end
      repeat (2) cyc();
      iRst_n = 1'b1;
      for (int t = 0; t < 100; t++) begin
         cyc();
         if (oCpuEn !== 1'b0) pulses++;
         if (oState !== 2'd0 || oHalted !== 1'b1) notHalt++;
      end
      nCmp++; if (pulses != 0)     begin nBad++; $display("FAIL idle_pulses: got %0d want 0", pulses); end
      nCmp++; if (notHalt != 0)    begin nBad++; $display("FAIL idle_state: got %0d non-halt cycles want 0", notHalt); end
      nCmp++; if (oInstCnt !== '0) begin nBad++; $display("FAIL idle_cnt: got %0h want 0", oInstCnt); end
   endtask

   task automatic test_run();
      for (int it = 0; it < 3; it++) begin
         int hold = $urandom_range(24, 60);
         int lat = 0;
         int pulses = 0;
         int cadErr = 0;
         int extra = 0;
         logic [CNT_W-1:0] startCnt = oInstCnt;
         logic [CNT_W-1:0] expCnt;
         iRun = 1'b1;
         while (oState !== 2'd1 && lat < 10) begin cyc(); lat++; end
         nCmp++; if (lat != 3) begin nBad++; $display("FAIL run_entry_latency: got %0d want 3", lat); end
         for (int t = 1; t <= hold; t++) begin
            cyc();
            if (oCpuEn !== ((t % DIV) == 0)) cadErr++;
            if (oState !== 2'd1 || oHalted !== 1'b0) cadErr++;
            if (oCpuEn === 1'b1) pulses++;
         end
         expCnt = startCnt + CNT_W'((hold - 1) / DIV);
         nCmp++; if (cadErr != 0) begin nBad++; $display("FAIL run_cadence: got %0d bad cycles want 0", cadErr); end
         nCmp++; if (pulses != hold / DIV) begin nBad++; $display("FAIL run_pulses: got %0d want %0d", pulses, hold / DIV); end
         nCmp++; if (oInstCnt !== expCnt) begin nBad++; $display("FAIL run_count: got %0h want %0h", oInstCnt, expCnt); end
         iRun = 1'b0;
         lat = 0;
         while (oState !== 2'd0 && lat < 8) begin cyc(); lat++; end
         nCmp++; if (lat > 3) begin nBad++; $display("FAIL run_stop_latency: got %0d want <=3", lat); end
         expCnt = oInstCnt;
         for (int t = 0; t < 20; t++) begin
            cyc();
            if (oCpuEn !== 1'b0 || oState !== 2'd0) extra++;
         end
         nCmp++; if (extra != 0) begin nBad++; $display("FAIL run_after_stop: got %0d bad cycles want 0", extra); end
         nCmp++; if (oInstCnt !== expCnt) begin nBad++; $display("FAIL run_stop_count: got %0h want %0h", oInstCnt, expCnt); end
      end
   endtask

   task automatic test_step();
      for (int rep = 0; rep < 2; rep++) begin
         int pulses = 0;
         int pulseIdx = -1;
         logic [1:0] stAtPulse = 2'd0;
         logic [CNT_W-1:0] expCnt;
         if (rep == 0) applyReset();
         expCnt = oInstCnt + CNT_W'(1);
         for (int k = 0; k < 3; k++) begin
            int hi = (rep == 0) ? 5 : $urandom_range(1, DEB - 1);
            int lo = (rep == 0) ? 2 : $urandom_range(1, 4);
            iStepBtn = 1'b1;
            for (int c = 0; c < hi; c++) begin cyc(); if (oCpuEn === 1'b1) pulses++; end
            iStepBtn = 1'b0;
            for (int c = 0; c < lo; c++) begin cyc(); if (oCpuEn === 1'b1) pulses++; end
         end
         iStepBtn = 1'b1;
         for (int idx = 1; idx <= 20; idx++) begin
            cyc();
            if (oCpuEn === 1'b1) begin pulses++; pulseIdx = idx; stAtPulse = oState; end
         end
         iStepBtn = 1'b0;
         for (int c = 0; c < 20; c++) begin cyc(); if (oCpuEn === 1'b1) pulses++; end
         nCmp++; if (pulses != 1) begin nBad++; $display("FAIL step_pulses: got %0d want 1", pulses); end
         nCmp++; if (pulseIdx != DEB + 4) begin nBad++; $display("FAIL step_latency: got %0d want %0d", pulseIdx, DEB + 4); end
         nCmp++; if (stAtPulse !== 2'd2) begin nBad++; $display("FAIL step_state: got %0d want 2", stAtPulse); end
         nCmp++; if (oState !== 2'd0 || oHalted !== 1'b1) begin nBad++; $display("FAIL step_return: got state %0d halted %b want 0/1", oState, oHalted); end
         nCmp++; if (oInstCnt !== expCnt) begin nBad++; $display("FAIL step_count: got %0h want %0h", oInstCnt, expCnt); end
      end
   endtask

   task automatic test_break();
      for (int it = 0; it < 2; it++) begin
         logic [31:0] brk = (it == 0) ? 32'h10 : 32'(4 * $urandom_range(1, 5));
         logic [31:0] pcs[$];
         logic [31:0] stepPc = 32'hFFFF_FFFF;
         int n = 0;
         int lat = 0;
         int pcErr = 0;
         int pulses = 0;
         int bad = 0;
         applyReset();
         iBrkEn = 1'b1;
         iBrkAddr = brk;
         iRun = 1'b1;
         while (oState !== 2'd3 && n < 100) begin
            cyc(); n++;
            if (oCpuEn === 1'b1) pcs.push_back(iPC);
         end
         for (int i = 0; i < pcs.size(); i++) if (pcs[i] !== 32'(4 * i)) pcErr++;
         nCmp++; if (oState !== 2'd3) begin nBad++; $display("FAIL brk_enter: got state %0d want 3", oState); end
         nCmp++; if (pcs.size() != int'(brk / 4)) begin nBad++; $display("FAIL brk_pulses: got %0d want %0d", pcs.size(), brk / 4); end
         nCmp++; if (pcErr != 0) begin nBad++; $display("FAIL brk_pc_seq: got %0d wrong PCs want 0", pcErr); end
         nCmp++; if (iPC !== brk || oCpuEn !== 1'b0 || oHalted !== 1'b1) begin nBad++; $display("FAIL brk_stop: got pc %0h en %b halted %b want %0h 0 1", iPC, oCpuEn, oHalted, brk); end
         nCmp++; if (oInstCnt !== CNT_W'(brk / 4)) begin nBad++; $display("FAIL brk_count: got %0h want %0h", oInstCnt, brk / 4); end
         for (int c = 0; c < 15; c++) begin
            cyc();
            if (oCpuEn !== 1'b0 || oState !== 2'd3) bad++;
         end
         nCmp++; if (bad != 0) begin nBad++; $display("FAIL brk_hold: got %0d bad cycles want 0", bad); end
         iStepBtn = 1'b1;
         for (int c = 0; c < 20; c++) begin cyc(); if (oCpuEn === 1'b1) begin pulses++; stepPc = iPC; end end
         iStepBtn = 1'b0;
         for (int c = 0; c < 16; c++) begin cyc(); if (oCpuEn === 1'b1) pulses++; end
         nCmp++; if (pulses != 1 || stepPc !== brk) begin nBad++; $display("FAIL brk_step: got %0d pulses at pc %0h want 1 at %0h", pulses, stepPc, brk); end
         nCmp++; if (oState !== 2'd0 || iPC !== brk + 32'd4) begin nBad++; $display("FAIL brk_step_halt: got state %0d pc %0h want 0 %0h", oState, iPC, brk + 32'd4); end
         nCmp++; if (oInstCnt !== CNT_W'(brk / 4 + 1)) begin nBad++; $display("FAIL brk_step_count: got %0h want %0h", oInstCnt, brk / 4 + 1); end
         iRun = 1'b0;
         repeat (5) cyc();
         iRun = 1'b1;
         while (oState !== 2'd1 && lat < 10) begin cyc(); lat++; end
         pulses = 0;
         for (int t = 1; t <= 3 * DIV; t++) begin cyc(); if (oCpuEn === 1'b1) pulses++; end
         nCmp++; if (oState !== 2'd1 || pulses != 3) begin nBad++; $display("FAIL brk_resume: got state %0d pulses %0d want 1 3", oState, pulses); end
         iRun = 1'b0;
         iBrkEn = 1'b0;
         repeat (10) cyc();
      end
   endtask

   task automatic test_collision();
      int runStart = -1;
      int stepSeen = 0;
      int cadErr = 0;
      int pulses = 0;
      applyReset();
      iStepBtn = 1'b1;
      repeat (DEB + 1) cyc();
      iRun = 1'b1;
      for (int t = 1; t <= 44; t++) begin
         cyc();
         if (oState === 2'd2) stepSeen++;
         if (runStart < 0 && oState === 2'd1) runStart = t;
         if (oCpuEn === 1'b1) begin
            pulses++;
            if (runStart < 0 || ((t - runStart) % DIV) != 0) cadErr++;
         end else if (runStart >= 0 && t > runStart && ((t - runStart) % DIV) == 0) begin
            cadErr++;
         end
         if (t == 6)  iStepBtn = 1'b0;
         if (t == 20) iStepBtn = 1'b1;
      end
      nCmp++; if (runStart != 3) begin nBad++; $display("FAIL coll_run_entry: got %0d want 3", runStart); end
      nCmp++; if (stepSeen != 0) begin nBad++; $display("FAIL coll_step_seen: got %0d want 0", stepSeen); end
      nCmp++; if (cadErr != 0)   begin nBad++; $display("FAIL coll_cadence: got %0d bad cycles want 0", cadErr); end
      nCmp++; if (pulses != (44 - 3) / DIV) begin nBad++; $display("FAIL coll_pulses: got %0d want %0d", pulses, (44 - 3) / DIV); end
      iRun = 1'b0;
      iStepBtn = 1'b0;
      repeat (20) cyc();
   endtask

   task automatic test_reset_mid_run();
      int k = $urandom_range(1, 4);
      int lat = 0;
      int bad = 0;
      applyReset();
      iRun = 1'b1;
      while (oState !== 2'd1 && lat < 10) begin cyc(); lat++; end
      for (int t = 1; t <= k * DIV + DIV - 1; t++) cyc();
      nCmp++; if (oInstCnt !== CNT_W'(k)) begin nBad++; $display("FAIL rst_pre_count: got %0h want %0h", oInstCnt, k); end
      iRst_n = 1'b0;
      #1;
      nCmp++; if (oState !== 2'd0 || oHalted !== 1'b1 || oCpuEn !== 1'b0 || oInstCnt !== '0) begin
         nBad++; $display("FAIL rst_async: got state %0d halted %b en %b cnt %0h want 0 1 0 0", oState, oHalted, oCpuEn, oInstCnt);
      end
      iRun = 1'b0;
      cyc();
      nCmp++; if (oCpuEn !== 1'b0 || oState !== 2'd0) begin nBad++; $display("FAIL rst_held: got en %b state %0d want 0 0", oCpuEn, oState); end
      iRst_n = 1'b1;
      for (int c = 0; c < 10; c++) begin
         cyc();
         if (oCpuEn !== 1'b0 || oState !== 2'd0 || oInstCnt !== '0) bad++;
      end
      nCmp++; if (bad != 0) begin nBad++; $display("FAIL rst_release: got %0d bad cycles want 0", bad); end
   endtask

   task automatic test_count_wrap();
      int n = 0;
      applyReset();
      force dut.instCnt = 16'hFFFF;
      repeat (2) cyc();
      release dut.instCnt;
      cyc();
      nCmp++; if (oInstCnt !== 16'hFFFF) begin nBad++; $display("FAIL wrap_preload: got %0h want ffff", oInstCnt); end
      iRun = 1'b1;
      while (oCpuEn !== 1'b1 && n < 16) begin cyc(); n++; end
      cyc();
      nCmp++; if (oInstCnt !== 16'h0000) begin nBad++; $display("FAIL wrap_count: got %0h want 0", oInstCnt); end
      iRun = 1'b0;
      repeat (10) cyc();
   endtask

   initial begin
      test_reset();
      test_run();
      test_step();
      test_break();
      test_collision();
      test_reset_mid_run();
      test_count_wrap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
      $finish;
   end

endmodule
